// File: rtl/noc_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// noc_arbiter_pkg
// Shared types and helpers for the NoC arbiter family.
//   weight_t      : widest supported weight field (callers zero-extend into it;
//                   WEIGHT_WIDTH of any arbiter must not exceed MAX_WEIGHT_WIDTH)
//   arb_state_t   : ownership FSM encoding (IDLE / OWNED)
//   index_width() : bits needed to index n requesters (minimum 1)
//   eff_weight()  : grant credit of a requester, a weight of 0 counts as 1
// ----------------------------------------------------------------------------
package noc_arbiter_pkg;

    localparam int MAX_WEIGHT_WIDTH = 16;

    typedef logic [MAX_WEIGHT_WIDTH-1:0] weight_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_t;

    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic weight_t eff_weight(input weight_t w);
        return (w == '0) ? weight_t'(1) : w;
    endfunction

endpackage

// File: rtl/noc_rotating_priority_picker.sv
// ----------------------------------------------------------------------------
// noc_rotating_priority_picker
// Combinational find-first-set that starts scanning just after a given index
// and wraps around, finishing on that index itself.
//   i_request  [N]  : request vector
//   i_last_idx [IW] : index scanned last (priority begins at i_last_idx+1)
//   o_onehot   [N]  : one-hot winner, all-zero when nothing requests
//   o_idx      [IW] : index of the winner (0 when nothing requests)
// ----------------------------------------------------------------------------
module noc_rotating_priority_picker #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  i_request,
    input  logic [IW-1:0] i_last_idx,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx
);

    logic          w_found;
    logic [IW-1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest requester after
    // i_last_idx is the last one written and therefore wins.
    always_comb begin
        int j;
        j       = 0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = N; i >= 1; i--) begin
            j = int'(i_last_idx) + i;
            if (j >= N) j = j - N;
            if (i_request[j[IW-1:0]]) begin
                w_found = 1'b1;
                w_idx   = j[IW-1:0];
            end
        end
    end

    assign o_idx    = w_idx;
    assign o_onehot = w_found ? (N'(1) << w_idx) : '0;

endmodule

// File: rtl/noc_weighted_round_robin_arbiter.sv
// ----------------------------------------------------------------------------
// noc_weighted_round_robin_arbiter
// Weighted round-robin arbiter with owner hold/release. A requester may win up
// to eff_weight consecutive grabs before priority rotates past it. The grant
// is combinational in the grab cycle and registered while the grant is owned.
//   clk, rst_n  : clock, synchronous active-low reset
//   i_weight    : per-requester weight, requester k at [k*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   i_request   : request vector
//   i_release   : owner releases its grant (only the owner's bit matters)
//   o_grant     : one-hot or zero grant
//   o_busy      : a grant is currently held
//   o_timeout   : one-cycle pulse on a forced release
// Optional: define NOC_ARBITER_OWNER_TIMEOUT_EN to force a release after
// TIMEOUT_CYCLES owned cycles; otherwise o_timeout is tied 0 and ownership
// is unbounded.
// ----------------------------------------------------------------------------
module noc_weighted_round_robin_arbiter
    import noc_arbiter_pkg::*;
#(
    parameter int REQUESTS       = 2,
    parameter int WEIGHT_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [REQUESTS*WEIGHT_WIDTH-1:0] i_weight,
    input  logic [REQUESTS-1:0]              i_request,
    output logic [REQUESTS-1:0]              o_grant,
    input  logic [REQUESTS-1:0]              i_release,
    output logic                             o_busy,
    output logic                             o_timeout
);

    localparam int IW = index_width(REQUESTS);

    arb_state_t              r_state;
    arb_state_t              w_next_state;
    logic [REQUESTS-1:0]     r_grant;
    logic [IW-1:0]           r_last;
    logic [WEIGHT_WIDTH-1:0] r_credit;

    logic                    w_grab;
    logic                    w_hold;
    logic                    w_release;
    logic                    w_force;
    logic [REQUESTS-1:0]     w_scan_onehot;
    logic [IW-1:0]           w_scan_idx;
    logic [REQUESTS-1:0]     w_next_grant;
    logic [IW-1:0]           w_next_idx;
    logic [REQUESTS-1:0]     w_grant;
    logic [WEIGHT_WIDTH-1:0] w_win_weight;
    weight_t                 w_win_eff;
    logic [WEIGHT_WIDTH-1:0] w_new_credit;

    assign w_grab = (r_state == ST_IDLE) && (|i_request);

    // The last owner keeps priority while it still has credit left.
    assign w_hold = i_request[r_last] && (r_credit != '0);

    noc_rotating_priority_picker #(
        .N  (REQUESTS),
        .IW (IW)
    ) u_picker (
        .i_request  (i_request),
        .i_last_idx (r_last),
        .o_onehot   (w_scan_onehot),
        .o_idx      (w_scan_idx)
    );

    assign w_next_grant = w_hold ? (REQUESTS'(1) << r_last) : w_scan_onehot;
    assign w_next_idx   = w_hold ? r_last : w_scan_idx;

    // A new owner starts with its full credit minus this grant; a repeat
    // winner (hold or wrap-around to itself) spends one, floored at zero.
    assign w_win_weight = i_weight[w_next_idx*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    assign w_win_eff    = eff_weight(weight_t'(w_win_weight));
    assign w_new_credit = (w_next_idx != r_last) ? WEIGHT_WIDTH'(w_win_eff - weight_t'(1)) :
                          (r_credit == '0)       ? '0 : (r_credit - WEIGHT_WIDTH'(1));

    assign w_release = |(i_release & w_grant);

`ifdef NOC_ARBITER_OWNER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TW-1:0] r_tcnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tcnt <= '0;
        end else if (w_grab) begin
            r_tcnt <= '0;
        end else if (r_state == ST_OWNED) begin
            r_tcnt <= r_tcnt + TW'(1);
        end
    end

    // A genuine release in the same cycle wins over the forced one.
    assign w_force = (r_state == ST_OWNED) && !w_release &&
                     (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign w_force = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_grab && !w_release)  w_next_state = ST_OWNED;
            ST_OWNED: if (w_release || w_force)  w_next_state = ST_IDLE;
            default:                             w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_grant = '0;
        case (r_state)
            ST_IDLE:  if (w_grab) w_grant = w_next_grant;
            ST_OWNED: w_grant = r_grant;
            default:  w_grant = '0;
        endcase
    end

    assign o_grant   = w_grant;
    assign o_busy    = (r_state == ST_OWNED);
    assign o_timeout = w_force;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grant  <= '0;
            r_last   <= IW'(REQUESTS - 1);
            r_credit <= '0;
        end else if (w_grab) begin
            r_grant  <= w_next_grant;
            r_last   <= w_next_idx;
            r_credit <= w_new_credit;
        end else if (w_force) begin
            // Drop the stalled owner's credit so priority rotates past it.
            r_credit <= '0;
        end
    end

endmodule

// File: tb/tb_noc_weighted_round_robin_arbiter.sv
module tb_noc_weighted_round_robin_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] i_weight;
    logic [3:0]  i_request;
    logic [3:0]  i_release;
    logic [3:0]  o_grant;
    logic        o_busy;
    logic        o_timeout;

    int n_assert = 0;
    int n_fail   = 0;

    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    noc_weighted_round_robin_arbiter #(
        .REQUESTS       (4),
        .WEIGHT_WIDTH   (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_weight  (i_weight),
        .i_request (i_request),
        .o_grant   (o_grant),
        .i_release (i_release),
        .o_busy    (o_busy),
        .o_timeout (o_timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at the falling edge, push the expected grant, then
    // sample 1 ns later and compare against the popped scoreboard entry.
    task automatic cyc(input logic [3:0] req, input logic [3:0] rel,
                       input logic [3:0] exp_g, input logic exp_b, input string tag);
        @(negedge clk);
        i_request = req;
        i_release = rel;
        exp_q.push_back(exp_g);
        #1;
        check(tag, 32'(o_grant), 32'(exp_q.pop_front()));
        check({tag, ".busy"}, 32'(o_busy), 32'(exp_b));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        i_request = '0;
        i_release = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset.grant",   32'(o_grant),   32'h0);
        check("reset.busy",    32'(o_busy),    32'h0);
        check("reset.timeout", 32'(o_timeout), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rr_seq [5];
        logic [3:0] wt_seq [8];
        rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        wt_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0010,
                   4'b0001, 4'b0001, 4'b0001, 4'b0010};

        rst_n     = 1'b0;
        i_weight  = 16'h1111;
        i_request = '0;
        i_release = '0;
        repeat (2) @(posedge clk);

        // Plain round-robin, release one cycle after each grant.
        do_reset();
        foreach (rr_seq[k]) begin
            cyc(4'hF, 4'h0,      rr_seq[k], 1'b0, "rr_grab");
            cyc(4'hF, rr_seq[k], rr_seq[k], 1'b1, "rr_release");
        end

        // Requester 0 weighted 3, requesters 0/1 competing, release in grab cycle.
        i_weight = 16'h1113;
        do_reset();
        foreach (wt_seq[k])
            cyc(4'h3, 4'hF, wt_seq[k], 1'b0, "weighted");

        // Single-cycle grant: request and release together while idle.
        i_weight = 16'h1111;
        do_reset();
        cyc(4'h4, 4'h4, 4'h4, 1'b0, "single_grab");
        cyc(4'h0, 4'h0, 4'h0, 1'b0, "single_after");

        // Owner 0010 ignores non-owner release and new requests.
        cyc(4'h2, 4'h0, 4'h2, 1'b0, "own_grab");
        cyc(4'hF, 4'h1, 4'h2, 1'b1, "own_nonowner1");
        cyc(4'hF, 4'h1, 4'h2, 1'b1, "own_nonowner2");
        cyc(4'hF, 4'h2, 4'h2, 1'b1, "own_release");
        cyc(4'h0, 4'h0, 4'h0, 1'b0, "own_after");

        // Reset while owned with credit 2.
        i_weight = 16'h1113;
        do_reset();
        cyc(4'h1, 4'h0, 4'h1, 1'b0, "midrst_grab");
        cyc(4'h0, 4'h0, 4'h1, 1'b1, "midrst_owned");
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst.grant", 32'(o_grant), 32'h0);
        check("midrst.busy",  32'(o_busy),  32'h0);
        cyc(4'hF, 4'h0, 4'h1, 1'b0, "midrst_regrab");
        cyc(4'hF, 4'h1, 4'h1, 1'b1, "midrst_release");

        // Owner that never releases.
        i_weight = 16'h1111;
        do_reset();
        cyc(4'hF, 4'h0, 4'h1, 1'b0, "to_grab");
`ifdef NOC_ARBITER_OWNER_TIMEOUT_EN
        for (int i = 1; i <= 7; i++) begin
            cyc(4'hF, 4'h0, 4'h1, 1'b1, "to_wait");
            check("to_wait.timeout", 32'(o_timeout), 32'h0);
        end
        cyc(4'hF, 4'h0, 4'h1, 1'b1, "to_force");
        check("to_force.timeout", 32'(o_timeout), 32'h1);
        cyc(4'hF, 4'h0, 4'h2, 1'b0, "to_next");
        check("to_next.timeout", 32'(o_timeout), 32'h0);
        cyc(4'hF, 4'h2, 4'h2, 1'b1, "to_next_release");
`else
        for (int i = 1; i <= 12; i++) begin
            cyc(4'hF, 4'h0, 4'h1, 1'b1, "hold_forever");
            check("hold_forever.timeout", 32'(o_timeout), 32'h0);
        end
        cyc(4'hF, 4'h1, 4'h1, 1'b1, "hold_release");
        cyc(4'hF, 4'h0, 4'h2, 1'b0, "hold_next");
        cyc(4'hF, 4'h2, 4'h2, 1'b1, "hold_next_release");
`endif

        // Lone requester with weight 2 is re-granted indefinitely.
        i_weight = 16'h1121;
        do_reset();
        for (int i = 0; i < 4; i++)
            cyc(4'h2, 4'hF, 4'h2, 1'b0, "lone");
        cyc(4'h0, 4'h0, 4'h0, 1'b0, "lone_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_weighted_round_robin_arbiter.md
Name: noc_weighted_round_robin_arbiter

Overview:
- Successor to the NoC round-robin grant arbiter, generalised with per-requester weights (grant credits) and an owner-hold/release handshake.
- Sits in front of shared router output ports and virtual-channel muxes. One requester may take up to W consecutive grants before priority rotates.
- Grant is combinational in the grab cycle and registered while owned.

Parameters:
- REQUESTS, 2, number of requesters (≥2).
- WEIGHT_WIDTH, 4, width of each per-requester weight field.
- TIMEOUT_CYCLES, 256, owner timeout in cycles (used only with the optional feature; ≥2).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; synchronous, active-low
- i_weight  input  REQUESTS*WEIGHT_WIDTH  weight of requester k in bits [k*WEIGHT_WIDTH +: WEIGHT_WIDTH]; quasi-static
- i_request  input  REQUESTS  request vector
- o_grant  output  REQUESTS  one-hot or zero grant
- i_release  input  REQUESTS  owner releases grant (end of packet)
- o_busy  output  1  a grant is held (registered state)
- o_timeout  output  1  one-cycle pulse on forced release (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (synchronous, rst_n=0 at a clk edge):
  - busy=0, current_grant=0, last_owner=REQUESTS-1, credit=0.
  - o_grant=0, o_busy=0, o_timeout=0.
  - Reset mid-ownership drops the grant on the next edge, with no release needed.
- States: IDLE (busy=0) and OWNED (busy=1).
- grab = ~busy & |i_request.
- IDLE, grab:
  - o_grant = next_grant combinationally in the same cycle.
  - Next edge: busy=1, current_grant=next_grant.
- OWNED: o_grant = current_grant; requests are ignored.
- Release condition: |(i_release & o_grant).
  - OWNED: o_grant stays asserted during the release cycle; busy=0 from the next edge. Earliest new grab is the cycle after.
  - Grab cycle: release asserted together with grab gives a single-cycle grant; busy stays 0.
  - Release bits for non-owners are ignored.
- Selection (next_grant):
  - Let o = last_owner.
  - If i_request[o]=1 and credit>0: select o ("hold").
  - Else: first requesting index scanning o+1, o+2, … wrapping modulo REQUESTS, ending at o itself.
- Credit update on each grab:
  - Winner w ≠ o: last_owner=w, credit = eff_weight(w)-1.
  - Winner w = o (hold or wrap-around): credit = credit-1, saturating at 0.
  - eff_weight = weight, except 0 is treated as 1. Weight is sampled only at grab.
- Result: requester k receives at most eff_weight(k) consecutive grants while others request. With a lone requester, it is re-granted indefinitely (credit saturates at 0; scan returns o).
- All weights = 1 reproduces plain round-robin behaviour.
- Invariant: o_grant is always one-hot or zero.

Optional Feature:
- Macro: NOC_ARBITER_OWNER_TIMEOUT_EN.
- Defined:
  - A counter clears on grab and increments each OWNED cycle.
  - When it reaches TIMEOUT_CYCLES-1 without a release, the arbiter forces release: busy=0 next edge, o_timeout=1 for that cycle, and credit is zeroed so priority rotates away from the stalled owner.
  - A real release in the same cycle takes precedence: no pulse.
- Undefined: no counter exists, o_timeout is tied 0, and ownership is unbounded.

Decomposition:
- Package noc_arbiter_pkg:
  - weight typedef: logic [WEIGHT_WIDTH-1:0] via parameterised function/class-free localparam helpers.
  - Index-width helper: $clog2(REQUESTS).
  - eff_weight function.
- Sub-module noc_rotating_priority_picker: combinational find-first-set starting after a given index, producing a one-hot output plus an index. It is reusable by other arbiters.
- The top holds the FSM, credit counter, last_owner and timeout counter.

Test Plan:
- REQUESTS=4, all weights 1, i_request=4'b1111 with release one cycle after each grant → grants cycle 0001, 0010, 0100, 1000, 0001.
- Weights {k0:3, others:1}, constant requests 4'b0011 with immediate releases → grant sequence 01, 01, 01, 10, 01, 01, 01, 10.
- Idle, i_request=4'b0100 with i_release=4'b0100 in the same cycle → o_grant=0100 for exactly 1 cycle, o_busy stays 0.
- Owner 0010 holds; i_release=4'b0001 (non-owner) → grant unchanged. Then i_release=4'b0010 → o_busy falls next edge.
- Assert rst_n=0 for one edge while owned with credit=2 → next cycle o_grant=0, o_busy=0, and the first subsequent grab with all requesting picks requester 0.
- With NOC_ARBITER_OWNER_TIMEOUT_EN and TIMEOUT_CYCLES=8, owner never releases → o_timeout pulses exactly once, 8 cycles after the grab. The next grant goes to the next requester in round-robin order, not the stalled owner.
